serial_subtractor: RTL

- Multi-cycle, bit-serial unsigned/two's-complement subtractor: computes `minuend - subtrahend` one bit per cycle, LSB first, through a single borrow-chain cell.
- Used as a low-area execution unit in the arithmetic library, the complement of the add path.
- Operands arrive and results leave over valid/ready handshakes.
- A synchronous flush discards an in-flight operation on pipeline squash.

---
 rtl/serial_subtractor.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one borrow-chain cell processes minuend - subtrahend LSB first,
// with valid/ready handshakes on both sides and a synchronous flush.
module serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] diff,
   output logic             bOut,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_borrow;
   logic             r_aMsb;
   logic             r_bMsb;
   logic             r_bOut;
   logic             r_ovf;

   logic             w_d;
   logic             w_borrow;
   logic             w_last;
   logic [WIDTH-1:0] w_acc;

   assign w_d      = r_a[0] ^ r_b[0] ^ r_borrow;
   assign w_borrow = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_acc    = {w_d, r_acc[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (inValid) w_next = S_RUN;
         S_RUN:   if (w_last)  w_next = S_DONE;
         S_DONE:  if (outReady) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (flush) w_next = S_IDLE;
   end

   // Results are published only on the final RUN edge, so diff/bOut/overflow hold
   // their previous values while a new operation is being shifted through r_acc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_aMsb   <= 1'b0;
         r_bMsb   <= 1'b0;
         r_bOut   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (flush) begin
         r_cnt    <= '0;
         r_borrow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (inValid) begin
                  r_a      <= minuend;
                  r_b      <= subtrahend;
                  r_aMsb   <= minuend[WIDTH-1];
                  r_bMsb   <= subtrahend[WIDTH-1];
                  r_cnt    <= '0;
                  r_borrow <= 1'b0;
               end
            end
            S_RUN: begin
               r_a      <= {1'b0, r_a[WIDTH-1:1]};
               r_b      <= {1'b0, r_b[WIDTH-1:1]};
               r_acc    <= w_acc;
               r_borrow <= w_borrow;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_diff <= w_acc;
                  r_bOut <= w_borrow;
                  r_ovf  <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
               end
            end
            default: ;
         endcase
      end
   end

   assign inReady  = (r_state == S_IDLE);
   assign outValid = (r_state == S_DONE);
   assign diff     = r_diff;
   assign bOut     = r_bOut;
   assign overflow = r_ovf;

endmodule
